hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage CPU: the producer side of the stall/clear interface that the pipeline registers (`floprc`, enabled flops) consume. It detects load-use and taken-branch hazards and sequences multi-cycle memory-stage stalls. Its `flush_*` outputs drive the `clear` inputs of the D and E pipeline registers, and its `stall_*` outputs drive their enable inverses. It is registered-state (memory-wait FSM), with combinational decode of the current-cycle hazards.

## Interface
- `REG_ADDR_W`, 4: register-file address width.
- `MEM_LAT`, 3: total memory-access cycles, ≥2; the M stage holds for `MEM_LAT` cycles.
- `CNT_W`, `$clog2(MEM_LAT)`: wait-counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rs1_d` in `REG_ADDR_W`: decode-stage source register 1.
- `rs2_d` in `REG_ADDR_W`: decode-stage source register 2.
- `rd_e` in `REG_ADDR_W`: execute-stage destination register.
- `memtoreg_e` in 1: execute-stage instruction is a load.
- `pcsrc_e` in 1: branch/jump taken, resolved in E.
- `mem_req_m` in 1: memory-stage instruction accesses data memory.
- `stall_f` out 1: hold PC.
- `stall_d` out 1: hold F/D register.
- `stall_e` out 1: hold D/E register.
- `stall_m` out 1: hold E/M register.
- `flush_d` out 1: clear F/D register.
- `flush_e` out 1: clear D/E register.
- `busy` out 1: FSM not in IDLE.

## Operation
- **States:** IDLE, WAIT, RELEASE. Counter `cnt` has `CNT_W` bits.
- **IDLE, `mem_req_m`=1:** assert all four `stall_*` this cycle. Next state is WAIT with `cnt` ← `MEM_LAT`-2.
  - With `MEM_LAT`=2, WAIT lasts one cycle.
- **WAIT:** assert all `stall_*`.
  - If `cnt`==0, next state is RELEASE.
  - Otherwise decrement `cnt`.
- **RELEASE:** all `stall_*` low so the pipeline advances. `mem_req_m` is ignored, because the same instruction is still presented. Next state is IDLE.
- **Load-use:** `memtoreg_e` && `rd_e`≠0 && (`rd_e`==`rs1_d` || `rd_e`==`rs2_d`) → `stall_f`=1, `stall_d`=1, `flush_e`=1 for one cycle.
- **Taken branch:** `pcsrc_e`=1 → `flush_d`=1, `flush_e`=1.
- **Priority, highest first:**
  1. Memory stall (IDLE+`mem_req_m`, or WAIT). `flush_d`, `flush_e` and load-use are suppressed; the held E-stage branch re-presents `pcsrc_e` later.
  2. Taken branch. The load-use stall is suppressed, and `flush_e` is asserted regardless.
  3. Load-use.
- In RELEASE, branch and load-use rules apply normally.
- `busy` = (state≠IDLE).

## Timing
- **Reset values:** state IDLE, `cnt`=0. While `reset` is high, every output is 0.
- **Reset mid-WAIT:**
  - Return to IDLE on the next edge.
  - No RELEASE cycle.
  - Stalls drop in the reset cycle.
- **Combinational outputs:** hazard outputs are a function of the current state and current inputs, with zero-cycle latency to the pipeline registers.
- **Stall timing:** a memory request first seen at cycle N stalls cycles N..N+`MEM_LAT`-1. RELEASE is cycle N+`MEM_LAT`. The earliest new request is accepted in cycle N+`MEM_LAT`+1.
- **Back-to-back memory ops:** a new `mem_req_m` in the IDLE cycle after RELEASE starts a new sequence immediately.
- **Register x0:** `rd_e`=0 never causes a load-use stall.

## Structure
- **Package `hazard_pkg`:**
  - enum `hz_state_t` {HZ_IDLE, HZ_WAIT, HZ_RELEASE}.
  - localparam `REG_ZERO` = '0.
- **Modules:** one module. The counter and FSM stay inline, since they are too small to justify a sub-module. The load-use comparator may be a function in `hazard_pkg` (`load_use_hit`).

## Test plan
- **Reset:** `reset`=1 with `mem_req_m`=1, `pcsrc_e`=1 → all outputs 0 and `busy`=0. Release reset → normal decode on the next cycle.
- **Load-use:** `memtoreg_e`=1, `rd_e`=5, `rs2_d`=5 → `stall_f`=`stall_d`=`flush_e`=1 for exactly one cycle.
- **x0 load:** repeat with `rd_e`=0 → no stall.
- **Memory stall, `MEM_LAT`=3:** `mem_req_m` held high from cycle 0 → `stall_*`=1 in cycles 0,1,2. Cycle 3 is RELEASE with stalls 0 and `busy`=1. Cycle 4 is IDLE.
- **Branch during memory stall:** `pcsrc_e`=1 during WAIT → `flush_d`/`flush_e` stay 0 until RELEASE, then assert in RELEASE.
- **Branch vs. load-use:** `pcsrc_e`=1 with a load-use match (`rd_e`=3, `rs1_d`=3) → `flush_d`=`flush_e`=1, `stall_f`=`stall_d`=0.
- **Reset mid-operation:** assert `reset` in the second WAIT cycle → next state IDLE, no RELEASE. A new `mem_req_m` after reset starts a full `MEM_LAT` stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   // Memory-wait sequencer states.
   typedef enum logic [1:0] {
      HZ_IDLE    = 2'd0,
      HZ_WAIT    = 2'd1,
      HZ_RELEASE = 2'd2
   } hz_state_t;

   // One bit of the hard-wired zero register address. Replicate it to any
   // register-address width so the x0 comparison never has a width mismatch.
   localparam logic REG_ZERO = '0;

endpackage : hazard_pkg

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage CPU. It produces the
// stall/clear signals for the pipeline registers. A small FSM sequences
// multi-cycle memory-stage waits. Load-use and taken-branch hazards are
// decoded combinationally from the current inputs.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 4,
   parameter int MEM_LAT    = 3,
   parameter int CNT_W      = $clog2(MEM_LAT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic [REG_ADDR_W-1:0] rd_e,
   input  logic                  memtoreg_e,
   input  logic                  pcsrc_e,
   input  logic                  mem_req_m,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  stall_e,
   output logic                  stall_m,
   output logic                  flush_d,
   output logic                  flush_e,
   output logic                  busy
);

   // The WAIT state is entered after the first stall cycle and ends after
   // MEM_LAT-1 stall cycles in total. So the counter is loaded with
   // MEM_LAT-2 and WAIT exits when it reads zero.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 2);

   hz_state_t        state;
   hz_state_t        state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             mem_stall;
   logic             load_use;

   // Load-use detection. A load into x0 never creates a dependency.
   assign load_use = memtoreg_e
                     && (rd_e != {REG_ADDR_W{REG_ZERO}})
                     && ((rd_e == rs1_d) || (rd_e == rs2_d));

   // State and wait-counter register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, regardless of statement order.
      if (reset) begin
         state <= HZ_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic for the memory-wait sequencer.
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves one unassigned, which would infer a latch.
      state_next = state;
      cnt_next   = cnt;
      mem_stall  = 1'b0;
      unique case (state)
         HZ_IDLE: begin
            if (mem_req_m) begin
               mem_stall  = 1'b1;
               state_next = HZ_WAIT;
               cnt_next   = CNT_LOAD;
            end
         end
         HZ_WAIT: begin
            mem_stall = 1'b1;
            if (cnt == '0) begin
               state_next = HZ_RELEASE;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         HZ_RELEASE: begin
            // The instruction that was waiting is still on mem_req_m this
            // cycle. Ignore it and let the pipeline advance past it.
            state_next = HZ_IDLE;
         end
         default: begin
            state_next = HZ_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Hazard outputs, in priority order: memory stall, taken branch, load-use.
   // Reset forces every output low, even if state still holds WAIT.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      busy    = 1'b0;
      if (!reset) begin
         busy = (state != HZ_IDLE);
         if (mem_stall) begin
            // Freeze the whole front of the pipe. A branch held in E
            // presents pcsrc_e again once the stall ends.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
         end else if (pcsrc_e) begin
            // A taken branch kills the wrong-path instructions in D and E.
            // This also covers any load-use bubble.
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (load_use) begin
            // Hold F and D for one cycle and insert a bubble into E.
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_LAT=3). Each step drives one
// cycle of inputs and pushes the expected output vector to a scoreboard.
// The observed vector is captured on the falling edge. Each test task then
// drains both queues and compares them inline.
module tb_hazard_ctrl;

   localparam int REG_ADDR_W = 4;
   localparam int MEM_LAT    = 3;

   // Output vector layout: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, busy}
   localparam logic [6:0] O_NONE   = 7'b0000_00_0;
   localparam logic [6:0] O_MEMREQ = 7'b1111_00_0;  // IDLE + request
   localparam logic [6:0] O_WAIT   = 7'b1111_00_1;
   localparam logic [6:0] O_REL    = 7'b0000_00_1;
   localparam logic [6:0] O_REL_BR = 7'b0000_11_1;
   localparam logic [6:0] O_REL_LU = 7'b1100_01_1;
   localparam logic [6:0] O_LU     = 7'b1100_01_0;
   localparam logic [6:0] O_BR     = 7'b0000_11_0;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rd_e;
   logic                  memtoreg_e, pcsrc_e, mem_req_m;
   logic                  stall_f, stall_d, stall_e, stall_m;
   logic                  flush_d, flush_e, busy;

   logic [6:0] exp_q[$];
   logic [6:0] obs_q[$];
   int         vectors     = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .REG_ADDR_W (REG_ADDR_W),
      .MEM_LAT    (MEM_LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rs1_d      (rs1_d),
      .rs2_d      (rs2_d),
      .rd_e       (rd_e),
      .memtoreg_e (memtoreg_e),
      .pcsrc_e    (pcsrc_e),
      .mem_req_m  (mem_req_m),
      .stall_f    (stall_f),
      .stall_d    (stall_d),
      .stall_e    (stall_e),
      .stall_m    (stall_m),
      .flush_d    (flush_d),
      .flush_e    (flush_e),
      .busy       (busy)
   );

   // Drive one cycle of inputs shortly after a rising edge, push the
   // expected outputs, then capture the observed outputs on the falling edge.
   task automatic step(input logic rst, input logic req, input logic br,
                       input logic ld, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [6:0] expv);
      reset      = rst;
      mem_req_m  = req;
      pcsrc_e    = br;
      memtoreg_e = ld;
      rd_e       = rd;
      rs1_d      = rs1;
      rs2_d      = rs2;
      exp_q.push_back(expv);
      @(negedge clk);
      obs_q.push_back({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, busy});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] e, o;
      int         cyc = 0;
      step(1, 1, 1, 0, 4'd0, 4'd0, 4'd0, O_NONE);
      step(1, 1, 1, 1, 4'd2, 4'd2, 4'd0, O_NONE);
      step(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, O_BR);    // normal decode right after reset
      step(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, O_NONE);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL test_reset cyc%0d: got %b expected %b", cyc, o, e);
         end
         cyc++;
      end
   endtask

   task automatic test_load_use();
      logic [6:0] e, o;
      int         cyc = 0;
      step(0, 0, 0, 1, 4'd5, 4'd1, 4'd5, O_LU);    // rs2 match
      step(0, 0, 0, 0, 4'd5, 4'd1, 4'd5, O_NONE);  // no longer a load
      step(0, 0, 0, 1, 4'd7, 4'd7, 4'd2, O_LU);    // rs1 match
      step(0, 0, 0, 1, 4'd7, 4'd6, 4'd2, O_NONE);  // load, no match
      step(0, 0, 0, 1, 4'd0, 4'd0, 4'd0, O_NONE);  // x0 load never stalls
      step(0, 0, 0, 1, 4'd0, 4'd3, 4'd0, O_NONE);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL test_load_use cyc%0d: got %b expected %b", cyc, o, e);
         end
         cyc++;
      end
   endtask

   task automatic test_mem_stall();
      logic [6:0] e, o;
      int         cyc = 0;
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_MEMREQ);
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_WAIT);
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_WAIT);
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_REL);   // request ignored in RELEASE
      step(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, O_NONE);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL test_mem_stall cyc%0d: got %b expected %b", cyc, o, e);
         end
         cyc++;
      end
   endtask

   task automatic test_branch_in_mem();
      logic [6:0] e, o;
      int         cyc = 0;
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_MEMREQ);
      step(0, 1, 1, 0, 4'd0, 4'd0, 4'd0, O_WAIT);  // branch suppressed
      step(0, 1, 1, 1, 4'd4, 4'd4, 4'd0, O_WAIT);  // branch + load-use suppressed
      step(0, 1, 1, 0, 4'd0, 4'd0, 4'd0, O_REL_BR);
      step(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, O_NONE);
      step(0, 0, 1, 1, 4'd3, 4'd3, 4'd0, O_BR);    // branch beats load-use
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL test_branch_in_mem cyc%0d: got %b expected %b", cyc, o, e);
         end
         cyc++;
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] e, o;
      int         cyc = 0;
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_MEMREQ);
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_WAIT);
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_WAIT);
      step(0, 1, 0, 1, 4'd9, 4'd0, 4'd9, O_REL_LU); // load-use applies in RELEASE
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_MEMREQ); // new sequence right away
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_WAIT);
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_WAIT);
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_REL);
      step(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, O_NONE);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL test_back_to_back cyc%0d: got %b expected %b", cyc, o, e);
         end
         cyc++;
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] e, o;
      int         cyc = 0;
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_MEMREQ);
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_WAIT);
      step(1, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_NONE);   // reset in second WAIT cycle
      step(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, O_NONE);   // back in IDLE, no RELEASE
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_MEMREQ); // full-length stall again
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_WAIT);
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_WAIT);
      step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, O_REL);
      step(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, O_NONE);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL test_reset_mid cyc%0d: got %b expected %b", cyc, o, e);
         end
         cyc++;
      end
   endtask

   initial begin
      reset      = 1'b1;
      mem_req_m  = 1'b0;
      pcsrc_e    = 1'b0;
      memtoreg_e = 1'b0;
      rd_e       = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_mem_stall();
      test_branch_in_mem();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_hazard_ctrl
